// File: rtl/genreg_bus_controller.sv
// Generic register bus sequencer: decodes the R5 control word, runs one req/ack
// transaction with a timeout, captures read data and keeps sticky status.
module genreg_bus_controller #(
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           addr_ctrl,
    input  logic [31:0]           wr_data,
    input  logic                  ctrl_we,
    output logic [31:0]           rd_data,
    output logic [31:0]           status,
    output logic                  busy,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [31:0]           bus_wdata,
    input  logic [31:0]           bus_rdata,
    input  logic                  bus_ack,
    input  logic                  bus_err
);

    localparam logic [0:0]  S_IDLE  = 1'b0;
    localparam logic [0:0]  S_REQ   = 1'b1;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [31:0]           wdata;
    } txn_t;

    logic [0:0]  state;
    txn_t        txn;
    logic [15:0] req_cnt;
    logic [7:0]  txn_cnt;
    logic [31:0] rd_q;
    logic        done_q, err_q, tmo_q, ovr_q;

    logic start, clr, in_req, launch, ack_done, err_done, to_done, complete;
    logic [15:0] addr_ext;

    assign start    = ctrl_we & addr_ctrl[31];
    assign clr      = ctrl_we & addr_ctrl[29];
    assign in_req   = (state == S_REQ);
    assign launch   = start & ~in_req;
    // Error takes priority over a simultaneous ack; ack in the last cycle beats timeout.
    assign err_done = in_req & bus_err;
    assign ack_done = in_req & bus_ack & ~bus_err;
    assign to_done  = in_req & ~bus_ack & ~bus_err & (req_cnt == TO_LAST);
    assign complete = err_done | ack_done | to_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            txn     <= '0;
            req_cnt <= '0;
            txn_cnt <= '0;
            rd_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            if (clr) begin
                done_q <= 1'b0;
                err_q  <= 1'b0;
                tmo_q  <= 1'b0;
                ovr_q  <= 1'b0;
            end
            if (launch) begin
                txn.we    <= addr_ctrl[30];
                txn.addr  <= addr_ctrl[ADDR_WIDTH-1:0];
                txn.wdata <= wr_data;
                done_q    <= 1'b0;
                err_q     <= 1'b0;
                tmo_q     <= 1'b0;
                req_cnt   <= '0;
                state     <= S_REQ;
            end
            // A start while busy is dropped; only the sticky flag records it.
            if (start && in_req)
                ovr_q <= 1'b1;
            if (in_req) begin
                if (complete) begin
                    state   <= S_IDLE;
                    done_q  <= 1'b1;
                    txn_cnt <= txn_cnt + 8'd1;
                    if (err_done)
                        err_q <= 1'b1;
                    if (to_done)
                        tmo_q <= 1'b1;
                    if (ack_done && !txn.we)
                        rd_q <= bus_rdata;
                end else begin
                    req_cnt <= req_cnt + 16'd1;
                end
            end
        end
    end

    always_comb begin
        addr_ext = '0;
        addr_ext[ADDR_WIDTH-1:0] = txn.addr;
    end

    assign bus_req   = in_req;
    assign busy      = in_req;
    assign bus_we    = txn.we;
    assign bus_addr  = txn.addr;
    assign bus_wdata = txn.wdata;
    assign rd_data   = rd_q;
    assign status    = {addr_ext, txn_cnt, 3'b000, ovr_q, tmo_q, err_q, done_q, in_req};

endmodule
